// File: rtl/riscv_pkg.sv
// Constants shared by the fetch, decode and hazard stages of the RISC-V pipeline.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT     = 32'd4;
  localparam int          IMEM_ADDR_W      = 10;

endpackage : riscv_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures the fetched PC/instruction, holds on stall,
// and turns into a NOP bubble on flush. Flush wins over hold.
module if_id_register
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        valid,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    // The PC of a flushed slot is left untouched; only the payload is squashed.
    if (flush) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (!hold) begin
      pc_d    = pc;
      instr_d = instruction;
      valid_d = valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= 32'h0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_pc          = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_valid       = valid_q;

endmodule : if_id_register

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register with redirect/stall/advance next-PC selection,
// word address to the combinational IMEM, and the IF/ID register.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [IMEM_ADDR_W-1:0] imem_address,
  input  logic [31:0]            imem_instruction,
  output logic [31:0]            pc,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_instruction,
  output logic                   if_id_valid
);

  // Only the word part of the PC is stored; the byte offset is always zero.
  logic [29:0] pc_q, pc_d;
  logic        unused_redirect_offset;

  assign unused_redirect_offset = ^redirect_pc[1:0];

  always_comb begin
    pc_d = pc_q + PC_INCREMENT[31:2];
    if (redirect) begin
      pc_d = redirect_pc[31:2];
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC[31:2];
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc           = {pc_q, 2'b00};
  assign imem_address = pc_q[IMEM_ADDR_W-1:0];

  if_id_register #(
    .NOP (NOP)
  ) u_if_id (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc                (pc),
    .instruction       (imem_instruction),
    .valid             (1'b1),
    .hold              (stall),
    .flush             (redirect),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid)
  );

endmodule : instruction_fetch
